// File: rtl/regfile_sb.sv
// Multi-port architectural register file with write-to-read bypass and a
// per-register pending scoreboard used by decode to stall on outstanding producers.
module regfile_sb #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int NRP      = 2,
   parameter int ZERO_REG = 1,
   localparam int AW      = $clog2(NREGS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NRP*AW-1:0]     ra,
   output logic [NRP*XLEN-1:0]   rd_data,
   output logic [NRP-1:0]        rd_busy,
   input  logic                  we0,
   input  logic [AW-1:0]         wa0,
   input  logic [XLEN-1:0]       wd0,
   input  logic                  we1,
   input  logic [AW-1:0]         wa1,
   input  logic [XLEN-1:0]       wd1,
   input  logic                  iss_valid,
   input  logic [AW-1:0]         iss_rd,
   output logic [NREGS-1:0]      busy_vec
);

   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] busy;
   logic [NREGS-1:0] busy_nxt;
   logic             wr0_ok;
   logic             wr1_ok;

   assign wr0_ok = we0 && !(ZERO_REG != 0 && wa0 == '0);
   assign wr1_ok = we1 && !(ZERO_REG != 0 && wa1 == '0);

   // A new producer issued in the same cycle as a write-back supersedes it,
   // so set is applied after clear.
   always_comb begin
      busy_nxt = busy;
      for (int r = 0; r < NREGS; r++) begin
         if ((we0 && wa0 == AW'(r)) || (we1 && wa1 == AW'(r)))
            busy_nxt[r] = 1'b0;
         if (iss_valid && iss_rd == AW'(r))
            busy_nxt[r] = 1'b1;
      end
      if (ZERO_REG != 0)
         busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NREGS; r++)
            regs[r] <= '0;
         busy <= '0;
      end else begin
         if (wr0_ok)
            regs[wa0] <= wd0;
         if (wr1_ok)
            regs[wa1] <= wd1;
         busy <= busy_nxt;
      end
   end

   assign busy_vec = busy;

   for (genvar gi = 0; gi < NRP; gi++) begin : g_rport
      logic [AW-1:0] a;
      logic          hit0;
      logic          hit1;
      logic          zero_hit;

      assign a        = ra[gi*AW +: AW];
      assign hit0     = we0 && (wa0 == a) && !rst;
      assign hit1     = we1 && (wa1 == a) && !rst;
      assign zero_hit = (ZERO_REG != 0) && (a == '0);

      assign rd_data[gi*XLEN +: XLEN] = zero_hit ? '0  :
                                        hit1     ? wd1 :
                                        hit0     ? wd0 :
                                                   regs[a];
      assign rd_busy[gi] = busy[a] && !hit0 && !hit1 && !zero_hit;
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed, table-driven bench for regfile_sb with default parameters
// (32 x 32-bit, two read ports, hardwired zero register).
module tb_regfile_sb;

   localparam int XLEN = 32;
   localparam int NREGS = 32;
   localparam int NRP = 2;
   localparam int AW = 5;

   logic                clk;
   logic                rst;
   logic [NRP*AW-1:0]   ra;
   logic [NRP*XLEN-1:0] rd_data;
   logic [NRP-1:0]      rd_busy;
   logic                we0;
   logic [AW-1:0]       wa0;
   logic [XLEN-1:0]     wd0;
   logic                we1;
   logic [AW-1:0]       wa1;
   logic [XLEN-1:0]     wd1;
   logic                iss_valid;
   logic [AW-1:0]       iss_rd;
   logic [NREGS-1:0]    busy_vec;

   int checks = 0;
   int failures = 0;

   regfile_sb #(
      .XLEN(XLEN), .NREGS(NREGS), .NRP(NRP), .ZERO_REG(1)
   ) dut (
      .clk(clk), .rst(rst), .ra(ra), .rd_data(rd_data), .rd_busy(rd_busy),
      .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .busy_vec(busy_vec)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        we0;
      logic [4:0]  wa0;
      logic [31:0] wd0;
      logic        we1;
      logic [4:0]  wa1;
      logic [31:0] wd1;
      logic        iv;
      logic [4:0]  ird;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [31:0] e_d0;
      logic [31:0] e_d1;
      logic [1:0]  e_busy;
      logic [31:0] e_bvec;
   } vec_t;

   localparam int NV = 15;
   vec_t vec [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   initial begin
      // rst we0 wa0 wd0 we1 wa1 wd1 iv ird ra0 ra1 | e_d0 e_d1 e_busy e_bvec
      // 0: both ports write r5, port 1 wins on the bypass
      vec[0]  = '{1'b0, 1'b1, 5'd5, 32'h1111_1111, 1'b1, 5'd5, 32'h2222_2222, 1'b0, 5'd0, 5'd5, 5'd6,
                  32'h2222_2222, 32'h0, 2'b00, 32'h0};
      // 1: r5 from storage holds port 1 data
      vec[1]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0,
                  32'h2222_2222, 32'h0, 2'b00, 32'h0};
      // 2: write to r0 is dropped and not bypassed
      vec[2]  = '{1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd5,
                  32'h0, 32'h2222_2222, 2'b00, 32'h0};
      // 3: issue to r0
      vec[3]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd5,
                  32'h0, 32'h2222_2222, 2'b00, 32'h0};
      // 4: r0 never busy; issue r7 invisible this cycle
      vec[4]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd0, 5'd7,
                  32'h0, 32'h0, 2'b00, 32'h0};
      // 5: r7 busy on both ports
      vec[5]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7,
                  32'h0, 32'h0, 2'b11, 32'h80};
      // 6: r7 still busy; write r3 bypassed on port 1
      vec[6]  = '{1'b0, 1'b1, 5'd3, 32'h0000_3333, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd3,
                  32'h0, 32'h0000_3333, 2'b01, 32'h80};
      // 7: write-back r7 on port 1 clears rd_busy in the same cycle
      vec[7]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hCAFE_0007, 1'b0, 5'd0, 5'd7, 5'd3,
                  32'hCAFE_0007, 32'h0000_3333, 2'b00, 32'h80};
      // 8: busy_vec[7] cleared; issue r9
      vec[8]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd7, 5'd9,
                  32'hCAFE_0007, 32'h0, 2'b00, 32'h0};
      // 9: write-back and re-issue of r9 in one cycle
      vec[9]  = '{1'b0, 1'b1, 5'd9, 32'h0000_0099, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd9,
                  32'h0000_0099, 32'h0000_0099, 2'b00, 32'h200};
      // 10: r9 stays busy with new data; issue r3, write r4
      vec[10] = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h0000_4444, 1'b1, 5'd3, 5'd9, 5'd4,
                  32'h0000_0099, 32'h0000_4444, 2'b01, 32'h200};
      // 11: reset cycle with a write to r4: no bypass, pre-reset state visible
      vec[11] = '{1'b1, 1'b1, 5'd4, 32'h0000_0055, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd4,
                  32'h0000_3333, 32'h0000_4444, 2'b01, 32'h208};
      // 12: after reset everything is zero
      vec[12] = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd4,
                  32'h0, 32'h0, 2'b00, 32'h0};
      // 13: independent writes on both ports, bypassed
      vec[13] = '{1'b0, 1'b1, 5'd10, 32'hAAAA_000A, 1'b1, 5'd11, 32'hBBBB_000B, 1'b0, 5'd0, 5'd10, 5'd11,
                  32'hAAAA_000A, 32'hBBBB_000B, 2'b00, 32'h0};
      // 14: both from storage, ports swapped
      vec[14] = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd11, 5'd10,
                  32'hBBBB_000B, 32'hAAAA_000A, 2'b00, 32'h0};

      rst = 1'b1;
      ra = '0;
      we0 = 1'b0; wa0 = '0; wd0 = '0;
      we1 = 1'b0; wa1 = '0; wd1 = '0;
      iss_valid = 1'b0; iss_rd = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      for (int r = 0; r < NREGS; r++) begin
         ra = {5'd0, 5'(r)};
         @(negedge clk);
         check($sformatf("reset_rd_data r%0d", r), rd_data[31:0], 32'h0);
         if (r == 0) begin
            check("reset_busy_vec", busy_vec, 32'h0);
            check("reset_rd_busy", {30'd0, rd_busy}, 32'h0);
         end
         @(posedge clk);
         #1;
      end

      for (int i = 0; i < NV; i++) begin
         rst = vec[i].rst;
         we0 = vec[i].we0; wa0 = vec[i].wa0; wd0 = vec[i].wd0;
         we1 = vec[i].we1; wa1 = vec[i].wa1; wd1 = vec[i].wd1;
         iss_valid = vec[i].iv; iss_rd = vec[i].ird;
         ra = {vec[i].ra1, vec[i].ra0};
         @(negedge clk);
         check($sformatf("v%0d rd_data0", i), rd_data[31:0], vec[i].e_d0);
         check($sformatf("v%0d rd_data1", i), rd_data[63:32], vec[i].e_d1);
         check($sformatf("v%0d rd_busy0", i), {31'd0, rd_busy[0]}, {31'd0, vec[i].e_busy[0]});
         check($sformatf("v%0d rd_busy1", i), {31'd0, rd_busy[1]}, {31'd0, vec[i].e_busy[1]});
         check($sformatf("v%0d busy_vec", i), busy_vec, vec[i].e_bvec);
         @(posedge clk);
         #1;
      end

      // Issue and write-back of r12 in consecutive cycles on port 0
      rst = 1'b0; we0 = 1'b0; we1 = 1'b0;
      iss_valid = 1'b1; iss_rd = 5'd12; ra = {5'd12, 5'd12};
      @(posedge clk);
      #1 iss_valid = 1'b0;
      we0 = 1'b1; wa0 = 5'd12; wd0 = 32'h1234_5678;
      @(negedge clk);
      check("seq wb0 rd_busy", {30'd0, rd_busy}, 32'h0);
      check("seq wb0 rd_data", rd_data[31:0], 32'h1234_5678);
      check("seq wb0 busy_vec", busy_vec, 32'h0000_1000);
      @(posedge clk);
      #1 we0 = 1'b0;
      @(negedge clk);
      check("seq after busy_vec", busy_vec, 32'h0);
      check("seq after rd_data1", rd_data[63:32], 32'h1234_5678);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
